// File: rtl/reg_file_if.sv
// Decoder/execute-facing bus of the register file: three read ports, issue reservation,
// writeback, flags and the R15 redirect.
interface reg_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [2:0]        rd_en;
  logic [DATA_W-1:0] rd_data0;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [DATA_W-1:0] pc;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              flags_we;
  logic [3:0]        flags_in;
  logic [3:0]        flags;
  logic              hazard;
  logic              pc_wr_valid;
  logic [DATA_W-1:0] pc_wr_data;

  modport master (
    output rd_addr0, rd_addr1, rd_addr2, rd_en, pc, issue_en, issue_addr,
    output wr_en, wr_addr, wr_data, flags_we, flags_in,
    input  rd_data0, rd_data1, rd_data2, flags, hazard, pc_wr_valid, pc_wr_data
  );

  modport slave (
    input  rd_addr0, rd_addr1, rd_addr2, rd_en, pc, issue_en, issue_addr,
    input  wr_en, wr_addr, wr_data, flags_we, flags_in,
    output rd_data0, rd_data1, rd_data2, flags, hazard, pc_wr_valid, pc_wr_data
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with NZCV flags, three bypassed read ports and a
// pending-write scoreboard for RAW hazard detection. The top index aliases the PC.
module reg_file #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned PC_OFFSET = 8
) (
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave bus
);
  localparam int unsigned      NumRegs  = 2 ** ADDR_W;
  localparam int unsigned      NumPorts = 3;
  localparam logic [ADDR_W-1:0] PcAddr  = ADDR_W'(NumRegs - 1);

  // Entry PcAddr is never written and stays zero; the read mux never selects it.
  logic [DATA_W-1:0]  regs_q [NumRegs];
  logic [NumRegs-1:0] pending_q, pending_d;
  logic [3:0]         flags_q, flags_d;
  logic               pc_wr_valid_q, pc_wr_valid_d;
  logic [DATA_W-1:0]  pc_wr_data_q, pc_wr_data_d;

  logic [ADDR_W-1:0]  rd_addr [NumPorts];
  logic [DATA_W-1:0]  rd_data [NumPorts];
  logic [DATA_W-1:0]  pc_read;
  logic               wr_pc;
  logic               hazard_c;

  assign rd_addr[0] = bus.rd_addr0;
  assign rd_addr[1] = bus.rd_addr1;
  assign rd_addr[2] = bus.rd_addr2;

  assign pc_read = bus.pc + DATA_W'(PC_OFFSET);
  assign wr_pc   = bus.wr_en && (bus.wr_addr == PcAddr);

  // A same-cycle writeback both forwards its data and resolves the hazard.
  always_comb begin
    hazard_c = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      rd_data[i] = regs_q[rd_addr[i]];
      if (rd_addr[i] == PcAddr) begin
        rd_data[i] = pc_read;
      end else if (bus.wr_en && (bus.wr_addr == rd_addr[i])) begin
        rd_data[i] = bus.wr_data;
      end
      if (bus.rd_en[i] && (rd_addr[i] != PcAddr) && pending_q[rd_addr[i]] &&
          !(bus.wr_en && (bus.wr_addr == rd_addr[i]))) begin
        hazard_c = 1'b1;
      end
    end
  end

  // Clear before set so a new producer issued alongside the old writeback wins.
  always_comb begin
    pending_d = pending_q;
    if (bus.wr_en) begin
      pending_d[bus.wr_addr] = 1'b0;
    end
    if (bus.issue_en && (bus.issue_addr != PcAddr)) begin
      pending_d[bus.issue_addr] = 1'b1;
    end
    flags_d       = bus.flags_we ? bus.flags_in : flags_q;
    pc_wr_valid_d = wr_pc;
    pc_wr_data_d  = wr_pc ? bus.wr_data : pc_wr_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.wr_en && !wr_pc) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      flags_q       <= '0;
      pc_wr_valid_q <= 1'b0;
      pc_wr_data_q  <= '0;
    end else begin
      pending_q     <= pending_d;
      flags_q       <= flags_d;
      pc_wr_valid_q <= pc_wr_valid_d;
      pc_wr_data_q  <= pc_wr_data_d;
    end
  end

  assign bus.rd_data0    = rd_data[0];
  assign bus.rd_data1    = rd_data[1];
  assign bus.rd_data2    = rd_data[2];
  assign bus.hazard      = hazard_c;
  assign bus.flags       = flags_q;
  assign bus.pc_wr_valid = pc_wr_valid_q;
  assign bus.pc_wr_data  = pc_wr_data_q;
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected values are queued as stimulus is driven and
// popped against the DUT outputs at each sample point.
module tb_reg_file;
  logic clk;
  logic rst_n;

  reg_file_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  reg_file #(.DATA_W(32), .ADDR_W(4), .PC_OFFSET(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_t it;
    it.tag = tag;
    it.val = val;
    sb.push_back(it);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t it;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.rd_addr0   = '0;
    bus.rd_addr1   = '0;
    bus.rd_addr2   = '0;
    bus.rd_en      = '0;
    bus.pc         = '0;
    bus.issue_en   = 1'b0;
    bus.issue_addr = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.flags_we   = 1'b0;
    bus.flags_in   = '0;
    #12;
    rst_n = 1'b1;
    tick();

    // 1. reset state
    sb_push("reset_flags", 32'h0);
    sb_push("reset_pc_wr_valid", 32'h0);
    #1;
    sb_check(32'(bus.flags));
    sb_check(32'(bus.pc_wr_valid));
    for (int i = 0; i < 15; i++) begin
      bus.rd_addr0 = 4'(i);
      bus.rd_addr1 = 4'((i + 5) % 15);
      bus.rd_addr2 = 4'((i + 10) % 15);
      bus.rd_en    = 3'b111;
      sb_push("reset_rd0", 32'h0);
      sb_push("reset_rd1", 32'h0);
      sb_push("reset_rd2", 32'h0);
      sb_push("reset_hazard", 32'h0);
      #1;
      sb_check(bus.rd_data0);
      sb_check(bus.rd_data1);
      sb_check(bus.rd_data2);
      sb_check(32'(bus.hazard));
    end
    bus.pc       = 32'h100;
    bus.rd_addr0 = 4'd15;
    sb_push("r15_read", 32'h108);
    #1;
    sb_check(bus.rd_data0);
    bus.pc = 32'hFFFF_FFFC;
    sb_push("r15_wrap", 32'h4);
    #1;
    sb_check(bus.rd_data0);
    bus.pc    = 32'h100;
    bus.rd_en = 3'b000;

    // 2. write-through bypass, then stored value
    tick();
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 4'd3;
    bus.wr_data  = 32'hDEAD_BEEF;
    bus.rd_addr0 = 4'd3;
    bus.rd_addr1 = 4'd4;
    sb_push("bypass_r3", 32'hDEAD_BEEF);
    sb_push("bypass_other", 32'h0);
    #1;
    sb_check(bus.rd_data0);
    sb_check(bus.rd_data1);
    tick();
    bus.wr_en = 1'b0;
    sb_push("stored_r3", 32'hDEAD_BEEF);
    #1;
    sb_check(bus.rd_data0);
    for (int k = 0; k < 3; k++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'(10 + k);
      bus.wr_data = 32'h1111_0000 * (k + 1) + 32'(k);
      tick();
    end
    bus.wr_en    = 1'b0;
    bus.rd_addr0 = 4'd10;
    bus.rd_addr1 = 4'd11;
    bus.rd_addr2 = 4'd12;
    sb_push("stored_r10", 32'h1111_0000);
    sb_push("stored_r11", 32'h2222_0001);
    sb_push("stored_r12", 32'h3333_0002);
    #1;
    sb_check(bus.rd_data0);
    sb_check(bus.rd_data1);
    sb_check(bus.rd_data2);

    // 3. RAW hazard raised by issue, resolved by writeback
    bus.issue_en   = 1'b1;
    bus.issue_addr = 4'd5;
    tick();
    bus.issue_en = 1'b0;
    bus.rd_en    = 3'b001;
    bus.rd_addr0 = 4'd5;
    bus.rd_addr1 = 4'd0;
    bus.rd_addr2 = 4'd0;
    sb_push("hazard_r5", 32'h1);
    #1;
    sb_check(32'(bus.hazard));
    bus.rd_en = 3'b000;
    sb_push("hazard_gated", 32'h0);
    #1;
    sb_check(32'(bus.hazard));
    bus.rd_en   = 3'b001;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd5;
    bus.wr_data = 32'd7;
    sb_push("hazard_wb_resolve", 32'h0);
    sb_push("wb_bypass_r5", 32'd7);
    #1;
    sb_check(32'(bus.hazard));
    sb_check(bus.rd_data0);
    tick();
    bus.wr_en = 1'b0;
    sb_push("pending_r5_cleared", 32'h0);
    sb_push("stored_r5", 32'd7);
    #1;
    sb_check(32'(bus.hazard));
    sb_check(bus.rd_data0);
    // port 2 only
    bus.issue_en   = 1'b1;
    bus.issue_addr = 4'd6;
    tick();
    bus.issue_en = 1'b0;
    bus.rd_addr2 = 4'd6;
    bus.rd_en    = 3'b100;
    sb_push("hazard_port2", 32'h1);
    #1;
    sb_check(32'(bus.hazard));
    bus.rd_en = 3'b011;
    sb_push("hazard_port2_gated", 32'h0);
    #1;
    sb_check(32'(bus.hazard));
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd6;
    bus.wr_data = 32'h66;
    tick();

    // 4. simultaneous issue and writeback: set wins
    bus.issue_en   = 1'b1;
    bus.issue_addr = 4'd9;
    bus.wr_en      = 1'b1;
    bus.wr_addr    = 4'd9;
    bus.wr_data    = 32'h99;
    tick();
    bus.issue_en = 1'b0;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 3'b001;
    bus.rd_addr0 = 4'd9;
    sb_push("set_wins_hazard", 32'h1);
    sb_push("set_wins_data", 32'h99);
    #1;
    sb_check(32'(bus.hazard));
    sb_check(bus.rd_data0);
    // R15 is never reserved
    bus.issue_en   = 1'b1;
    bus.issue_addr = 4'd15;
    tick();
    bus.issue_en = 1'b0;
    bus.rd_addr0 = 4'd15;
    sb_push("r15_no_hazard", 32'h0);
    #1;
    sb_check(32'(bus.hazard));
    bus.rd_en = 3'b000;

    // 5. R15 writeback redirect
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 4'd15;
    bus.wr_data  = 32'h2000;
    bus.rd_addr0 = 4'd15;
    sb_push("r15_no_bypass", 32'h108);
    sb_push("pc_wr_valid_before", 32'h0);
    #1;
    sb_check(bus.rd_data0);
    sb_check(32'(bus.pc_wr_valid));
    tick();
    bus.wr_en = 1'b0;
    sb_push("pc_wr_valid", 32'h1);
    sb_push("pc_wr_data", 32'h2000);
    #1;
    sb_check(32'(bus.pc_wr_valid));
    sb_check(bus.pc_wr_data);
    tick();
    sb_push("pc_wr_valid_drop", 32'h0);
    sb_push("r15_after_write", 32'h108);
    #1;
    sb_check(32'(bus.pc_wr_valid));
    sb_check(bus.rd_data0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd15;
    bus.wr_data = 32'h3000;
    tick();
    bus.wr_data = 32'h4000;
    sb_push("b2b_valid0", 32'h1);
    sb_push("b2b_data0", 32'h3000);
    #1;
    sb_check(32'(bus.pc_wr_valid));
    sb_check(bus.pc_wr_data);
    tick();
    bus.wr_en = 1'b0;
    sb_push("b2b_valid1", 32'h1);
    sb_push("b2b_data1", 32'h4000);
    #1;
    sb_check(32'(bus.pc_wr_valid));
    sb_check(bus.pc_wr_data);
    tick();
    sb_push("b2b_valid_drop", 32'h0);
    #1;
    sb_check(32'(bus.pc_wr_valid));

    // 6. flags, then asynchronous reset mid-cycle
    bus.flags_we = 1'b1;
    bus.flags_in = 4'b1010;
    tick();
    bus.flags_we = 1'b0;
    bus.flags_in = 4'b0101;
    sb_push("flags_load", 32'hA);
    #1;
    sb_check(32'(bus.flags));
    bus.issue_en   = 1'b1;
    bus.issue_addr = 4'd2;
    tick();
    bus.issue_en = 1'b0;
    sb_push("flags_hold", 32'hA);
    #1;
    sb_check(32'(bus.flags));
    bus.rd_en    = 3'b001;
    bus.rd_addr0 = 4'd2;
    bus.rd_addr1 = 4'd3;
    sb_push("pending_r2_pre_reset", 32'h1);
    #1;
    sb_check(32'(bus.hazard));
    rst_n = 1'b0;
    sb_push("rst_flags", 32'h0);
    sb_push("rst_hazard", 32'h0);
    sb_push("rst_r3", 32'h0);
    #1;
    sb_check(32'(bus.flags));
    sb_check(32'(bus.hazard));
    sb_check(bus.rd_data1);
    rst_n = 1'b1;
    tick();

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
